tick_packetizer: RTL and testbench

Batches the 16-bit price ticks produced by the market generator into fixed-size UDP payloads and emits them as a byte stream with a valid/ready handshake. It sits between the price source and the UDP/IP framer. Ticks are buffered in an internal FIFO so that backpressure from the framer does not stall the source. Each payload carries a magic word, a sequence number, a tick count and big-endian prices.

---
 rtl/tick_packetizer.sv | 240 ++++++++++++++++++++++++
 tb/tb_tick_packetizer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_packetizer.sv
// tick_packetizer: buffers 16-bit price ticks in a FIFO and emits fixed-size payloads as a byte stream.
// Define TICK_PKT_CSUM_EN to append an XOR checksum byte (carrying m_last) to every payload.
//
// state   | meaning
// IDLE    | no packet in flight; waits until TICKS_PER_PKT ticks are buffered
// HDR     | magic, sequence number and tick count, hdr_idx 0..4
// PAYLOAD | prices hi then lo, tick_left counts down to the final tick
// CSUM    | trailing checksum byte (checksum build only)
module tick_packetizer #(
    parameter int          TICKS_PER_PKT = 8,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] SEQ_INIT      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] price,
    input  logic        price_valid,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] drop_cnt,
    output logic [15:0] pkt_cnt
);
    localparam int            AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] TPP_CNT   = CW'(TICKS_PER_PKT);
    localparam logic [7:0]    TPP_BYTE  = 8'(TICKS_PER_PKT);
    localparam logic [7:0]    TPP_LAST  = 8'(TICKS_PER_PKT - 1);
    localparam logic [7:0]    MAGIC_HI  = 8'h4D;
    localparam logic [7:0]    MAGIC_LO  = 8'h54;
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
`ifdef TICK_PKT_CSUM_EN
        , CSUM  = 2'd3
`endif
    } state_t;

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          accept;
    logic [15:0]   head;
    logic [15:0]   head_nxt;

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    hdr_idx;
    logic [2:0]    idx_d;
    logic [7:0]    tick_left;
    logic [7:0]    left_d;
    logic          lo_sel;
    logic          lo_d;
    logic [7:0]    data_d;
    logic          valid_d;
    logic          last_d;
    logic [7:0]    hdr_next;
    logic [15:0]   seq;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign push       = price_valid && !fifo_full;
    assign accept     = m_valid && m_ready;
    assign rd_ptr_nxt = ptr_inc(rd_ptr);
    assign head       = fifo_mem[rd_ptr];
    assign head_nxt   = fifo_mem[rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= price;
        end
    end

    // A push on a full FIFO is dropped even if a pop frees a slot in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end
            if (price_valid && fifo_full && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

`ifdef TICK_PKT_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if ((state_q == IDLE) && (state_d == HDR)) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ m_data;
        end
    end
`endif

    always_comb begin
        case (hdr_idx)
            3'd0:    hdr_next = MAGIC_LO;
            3'd1:    hdr_next = seq[15:8];
            3'd2:    hdr_next = seq[7:0];
            default: hdr_next = TPP_BYTE;
        endcase
    end

    // Outputs are registered, so each branch prepares the byte shown after the current one is taken.
    always_comb begin
        state_d = state_q;
        idx_d   = hdr_idx;
        left_d  = tick_left;
        lo_d    = lo_sel;
        data_d  = m_data;
        valid_d = m_valid;
        last_d  = m_last;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (fifo_cnt >= TPP_CNT) begin
                    state_d = HDR;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = MAGIC_HI;
                end
            end
            HDR: begin
                if (accept) begin
                    if (hdr_idx == 3'd4) begin
                        state_d = PAYLOAD;
                        left_d  = TPP_LAST;
                        lo_d    = 1'b0;
                        data_d  = head[15:8];
                    end else begin
                        idx_d  = hdr_idx + 3'd1;
                        data_d = hdr_next;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (!lo_sel) begin
                        lo_d   = 1'b1;
                        data_d = head[7:0];
`ifndef TICK_PKT_CSUM_EN
                        last_d = (tick_left == 8'd0);
`endif
                    end else begin
                        pop = 1'b1;
                        if (tick_left == 8'd0) begin
`ifdef TICK_PKT_CSUM_EN
                            state_d = CSUM;
                            data_d  = csum ^ m_data;
                            last_d  = 1'b1;
`else
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
`endif
                        end else begin
                            left_d = tick_left - 8'd1;
                            lo_d   = 1'b0;
                            data_d = head_nxt[15:8];
                        end
                    end
                end
            end
`ifdef TICK_PKT_CSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hdr_idx   <= '0;
            tick_left <= '0;
            lo_sel    <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            seq       <= SEQ_INIT;
            pkt_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx   <= idx_d;
            tick_left <= left_d;
            lo_sel    <= lo_d;
            m_data    <= data_d;
            m_valid   <= valid_d;
            m_last    <= last_d;
            if (accept && m_last) begin
                seq     <= seq + 16'd1;
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tick_packetizer.sv
// Bench for tick_packetizer: directed steps plus randomized traffic, checked against a
// queue-based payload model; a second instance starting at sequence 0xFFFF covers the wrap.
module tb_tick_packetizer;
    localparam int T      = 4;
    localparam int DEPTH  = 16;
    localparam int T_B    = 2;
`ifdef TICK_PKT_CSUM_EN
    localparam int CS     = 1;
`else
    localparam int CS     = 0;
`endif
    localparam int PLEN   = 5 + 2 * T + CS;
    localparam int PLEN_B = 5 + 2 * T_B + CS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] price = '0;
    logic        price_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic [15:0] drop_cnt;
    logic [15:0] pkt_cnt;

    logic [15:0] price_b = '0;
    logic        price_valid_b = 1'b0;
    logic        m_ready_b = 1'b0;
    logic [7:0]  m_data_b;
    logic        m_valid_b;
    logic        m_last_b;
    logic [15:0] drop_cnt_b;
    logic [15:0] pkt_cnt_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tick_packetizer #(.TICKS_PER_PKT(T), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .price(price), .price_valid(price_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
    );

    tick_packetizer #(.TICKS_PER_PKT(T_B), .FIFO_DEPTH(4), .SEQ_INIT(16'hFFFF)) dut_b (
        .clk(clk), .rst_n(rst_n), .price(price_b), .price_valid(price_valid_b),
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_last(m_last_b),
        .drop_cnt(drop_cnt_b), .pkt_cnt(pkt_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Payload model: ticks waiting in the FIFO, position inside the current payload.
    logic [15:0] mq[$];
    logic [7:0]  got[$];
    int          m_drops;
    int          m_pkts;
    int          pos;
    logic [15:0] m_seq;
    logic [7:0]  m_xor;
    logic [7:0]  p_data;
    logic        p_valid;
    logic        p_ready;
    logic        p_last;

    always @(negedge clk) begin
        logic       full_before;
        logic [7:0] exp_b;
        int         k;
        if (!rst_n) begin
            mq.delete();
            m_drops = 0;
            m_pkts  = 0;
            pos     = 0;
            m_seq   = '0;
            m_xor   = '0;
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_data  = '0;
            p_last  = 1'b0;
        end else begin
            if (p_valid && !p_ready)
                check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, p_last, p_data}));
            if (pos > 0)
                check("no_gap", 32'(m_valid), 32'd1);
            full_before = (mq.size() == DEPTH);
            if (m_valid && m_ready) begin
                exp_b = 8'hxx;
                k = pos - 5;
                if (pos == 0) exp_b = 8'h4D;
                else if (pos == 1) exp_b = 8'h54;
                else if (pos == 2) exp_b = m_seq[15:8];
                else if (pos == 3) exp_b = m_seq[7:0];
                else if (pos == 4) exp_b = 8'(T);
                else if (pos < 5 + 2 * T) begin
                    if (mq.size() > 0) exp_b = (k % 2 == 0) ? mq[0][15:8] : mq[0][7:0];
                end else exp_b = m_xor;
                check($sformatf("pkt_byte[%0d]", pos), 32'({m_last, m_data}),
                      32'({(pos == PLEN - 1), exp_b}));
                got.push_back(m_data);
                m_xor ^= m_data;
                if (pos >= 5 && pos < 5 + 2 * T && (k % 2 == 1) && mq.size() > 0)
                    void'(mq.pop_front());
                if (pos == PLEN - 1) begin
                    pos = 0;
                    m_seq++;
                    m_pkts++;
                    m_xor = '0;
                end else begin
                    pos++;
                end
            end
            if (price_valid) begin
                if (full_before) m_drops++;
                else mq.push_back(price);
            end
            p_valid = m_valid;
            p_ready = m_ready;
            p_data  = m_data;
            p_last  = m_last;
        end
    end

    task automatic push(input logic [15:0] v);
        price = v;
        price_valid = 1'b1;
        @(posedge clk); #1;
        price_valid = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] v);
        price_b = v;
        price_valid_b = 1'b1;
        @(posedge clk); #1;
        price_valid_b = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget, input bit rnd);
        int n;
        n = 0;
        while (!(m_valid === 1'b0 && pos == 0 && mq.size() < T) && n < budget) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
        m_ready = 1'b1;
    endtask

    logic [7:0]  basic_exp [13] = '{8'h4D, 8'h54, 8'h00, 8'h00, 8'h04, 8'h03, 8'hE8,
                                    8'h03, 8'hEB, 8'h03, 8'hE6, 8'h03, 8'hED};
    logic [15:0] bp [T];
    logic [7:0]  got_b[$];
    logic [7:0]  exp_q[$];
    logic [15:0] tb_ticks [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    task automatic build_b(input logic [15:0] s, input logic [15:0] t0, input logic [15:0] t1);
        logic [7:0] b [9];
        logic [7:0] x;
        b = '{8'h4D, 8'h54, s[15:8], s[7:0], 8'(T_B), t0[15:8], t0[7:0], t1[15:8], t1[7:0]};
        x = '0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(b[i]);
            x ^= b[i];
        end
        if (CS == 1) exp_q.push_back(x);
    endtask

    initial begin
        int n;
        int lasts;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_data", 32'(m_data), 32'h00);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;

        // Basic packet with the documented bytes and first-byte latency.
        got.delete();
        push(16'd1000); push(16'd1003); push(16'd998); push(16'd1005);
        @(negedge clk);
        check("start_latency_low", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("start_latency_high", 32'({m_valid, m_data}), 32'({1'b1, 8'h4D}));
        @(posedge clk); #1;
        drain("basic_timeout", 100, 1'b0);
        check("basic_len", 32'(got.size()), 32'(PLEN));
        for (int i = 0; i < 13; i++)
            if (i < got.size()) check($sformatf("basic_byte[%0d]", i), 32'(got[i]), 32'(basic_exp[i]));
`ifdef TICK_PKT_CSUM_EN
        if (got.size() > 13) check("basic_csum", 32'(got[13]), 32'h15);
`endif
        check("basic_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Backpressure: random m_ready during the whole packet.
        got.delete();
        for (int j = 0; j < T; j++) begin
            bp[j] = 16'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            push(bp[j]);
        end
        drain("bp_timeout", 400, 1'b1);
        check("bp_len", 32'(got.size()), 32'(PLEN));
        if (got.size() == PLEN) begin
            check("bp_seq", 32'({got[2], got[3]}), 32'h0001);
            for (int j = 0; j < T; j++)
                check($sformatf("bp_tick[%0d]", j), 32'({got[5 + 2 * j], got[6 + 2 * j]}), 32'(bp[j]));
        end

        // Overflow: 20 ticks into a 16-deep FIFO with the output stalled.
        got.delete();
        m_ready = 1'b0;
        for (int j = 0; j < 20; j++) push(16'h0100 + 16'(j));
        @(posedge clk); #1;
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
        check("ovf_m_valid", 32'(m_valid), 32'd1);
        drain("ovf_timeout", 400, 1'b0);
        check("ovf_len", 32'(got.size()), 32'(4 * PLEN));
        if (got.size() == 4 * PLEN)
            for (int j = 0; j < 16; j++)
                check($sformatf("ovf_tick[%0d]", j),
                      32'({got[(j / T) * PLEN + 5 + 2 * (j % T)], got[(j / T) * PLEN + 6 + 2 * (j % T)]}),
                      32'h0100 + 32'(j));

        // Random traffic against the model, including drops under congestion.
        for (int c = 0; c < 1500; c++) begin
            price = 16'($urandom);
            price_valid = ($urandom_range(0, 2) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        price_valid = 1'b0;
        drain("rand_timeout", 2000, 1'b0);
        check("rand_pkt_cnt", 32'(pkt_cnt), 32'(m_pkts));
        check("rand_drop_cnt", 32'(drop_cnt), 32'(m_drops));

        // Reset after byte 6 of a packet; stale ticks must vanish and SEQ restarts.
        got.delete();
        for (int j = 0; j < 7; j++) push(16'h0E00 + 16'(j));
        n = 0;
        while (got.size() < 7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_wait", 32'(got.size() >= 7), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({m_valid, m_last, m_data}), 32'd0);
        check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        for (int j = 0; j < T; j++) push(16'hA000 + 16'(j));
        drain("mid_timeout", 100, 1'b0);
        check("mid_len", 32'(got.size()), 32'(PLEN));
        if (got.size() == PLEN) begin
            check("mid_seq", 32'({got[2], got[3]}), 32'h0000);
            check("mid_first_tick", 32'({got[5], got[6]}), 32'h0000A000);
        end
        check("mid_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Sequence wrap on the instance that leaves reset at 0xFFFF.
        m_ready_b = 1'b0;
        for (int j = 0; j < 4; j++) push_b(tb_ticks[j]);
        m_ready_b = 1'b1;
        n = 0;
        lasts = 0;
        while (lasts < 2 && n < 200) begin
            @(negedge clk);
            if (m_valid_b && m_ready_b) begin
                got_b.push_back(m_data_b);
                if (m_last_b) lasts++;
            end
            n++;
        end
        check("wrap_lasts", 32'(lasts), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        build_b(16'hFFFF, tb_ticks[0], tb_ticks[1]);
        build_b(16'h0000, tb_ticks[2], tb_ticks[3]);
        check("wrap_len", 32'(got_b.size()), 32'(2 * PLEN_B));
        if (got_b.size() == 2 * PLEN_B) begin
            check("wrap_seq_first", 32'({got_b[2], got_b[3]}), 32'h0000FFFF);
            check("wrap_seq_second", 32'({got_b[PLEN_B + 2], got_b[PLEN_B + 3]}), 32'h0000);
            for (int i = 0; i < 2 * PLEN_B; i++)
                check($sformatf("wrap_byte[%0d]", i), 32'(got_b[i]), 32'(exp_q[i]));
        end
        check("wrap_pkt_cnt", 32'(pkt_cnt_b), 32'd2);
        check("wrap_drop_cnt", 32'(drop_cnt_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
